// File: rtl/lsu_ctrl_if.sv
// lsu_ctrl_if: bundles the CPU request/response and memory beat signals of
// lsu_ctrl. The slave modport is the LSU's view, the master modport is the
// view of whatever drives the CPU side and models the memory.
//
// Handshakes: a CPU request transfers on a cycle where i_req_valid and
// o_req_ready are both 1. A memory beat transfers on a cycle where o_mem_req
// and i_mem_ack are both 1, with i_mem_rdata valid in that same cycle. The
// beat fields stay stable while o_mem_req is 1 and i_mem_ack is 0.
// o_rsp_valid is a one-cycle pulse with no back-pressure.
interface lsu_ctrl_if #(
    parameter int ADDR_W = 16
) ();
    logic              i_req_valid;
    logic              o_req_ready;
    logic [ADDR_W-1:0] i_addr;
    logic              i_we;
    logic [2:0]        i_funct3;
    logic [31:0]       i_wdata;
    logic              o_rsp_valid;
    logic [31:0]       o_rdata;
    logic              o_err;
    logic              o_mem_req;
    logic              o_mem_we;
    logic [ADDR_W-1:0] o_mem_addr;
    logic              i_mem_ack;
    logic [31:0]       i_mem_rdata;
    logic [3:0]        o_mem_be;
    logic [31:0]       o_mem_wdata;

    modport slave (
        input  i_req_valid, i_addr, i_we, i_funct3, i_wdata,
        input  i_mem_ack, i_mem_rdata,
        output o_req_ready, o_rsp_valid, o_rdata, o_err,
        output o_mem_req, o_mem_we, o_mem_addr, o_mem_be, o_mem_wdata
    );

    modport master (
        output i_req_valid, i_addr, i_we, i_funct3, i_wdata,
        output i_mem_ack, i_mem_rdata,
        input  o_req_ready, o_rsp_valid, o_rdata, o_err,
        input  o_mem_req, o_mem_we, o_mem_addr, o_mem_be, o_mem_wdata
    );
endinterface

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit controller. Accepts one CPU access at a time,
// turns it into one or two word-aligned memory beats with byte-lane enables,
// and returns extended load data with a one-cycle response pulse.
// Optional feature macro: LSU_MISALIGN_EN. When defined, accesses that cross
// a word boundary are split into two beats; when undefined they are errors.
// Accesses are legal only when every byte touched lies in 0x2000-0x3FFF.
module lsu_ctrl #(
    parameter int ADDR_W = 16
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    lsu_ctrl_if.slave  bus
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BEAT0 = 2'd1;
`ifdef LSU_MISALIGN_EN
    localparam logic [1:0] BEAT1 = 2'd2;
`endif
    localparam logic [1:0] RESP  = 2'd3;

    // Number of bytes for the size encoded in funct3[1:0].
    function automatic logic [2:0] nbytes(input logic [1:0] sz);
        case (sz)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            2'b10:   return 3'd4;
            default: return 3'd1;
        endcase
    endfunction

    // Size-wide lane mask shifted by the byte offset; bits [7:4] spill into
    // the following word.
    function automatic logic [7:0] lane_mask(input logic [1:0] sz,
                                             input logic [1:0] off);
        logic [7:0] m;
        case (sz)
            2'b00:   m = 8'h01;
            2'b01:   m = 8'h03;
            2'b10:   m = 8'h0F;
            default: m = 8'h01;
        endcase
        return m << off;
    endfunction

    // Error decision for an incoming access. The legal region is contiguous,
    // so checking the first and last byte covers every byte touched.
    function automatic logic access_err(input logic [ADDR_W-1:0] a,
                                        input logic              we,
                                        input logic [2:0]        f3);
        logic [ADDR_W-1:0] last;
        logic              bad_f3;
        logic              region_ok;
        logic              e;
        bad_f3    = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) ||
                    (we && f3[2]);
        last      = a + ADDR_W'(nbytes(f3[1:0]) - 3'd1);
        region_ok = (a[15:13] == 3'b001) && (last[15:13] == 3'b001);
        e         = bad_f3 || !region_ok;
`ifndef LSU_MISALIGN_EN
        e = e || ((3'(a[1:0]) + nbytes(f3[1:0])) > 3'd4);
`endif
        return e;
    endfunction

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [31:0]       wdata_q;
    logic              err_q;
    logic [31:0]       r0_q;
    logic              accept;
    logic [4:0]        shamt;
    logic [3:0]        be0;
    logic [31:0]       wd0;
    logic [31:0]       raw;
    logic [31:0]       ext;

    assign accept = (state_q == IDLE) && bus.i_req_valid;
    assign shamt  = {addr_q[1:0], 3'b000};

`ifdef LSU_MISALIGN_EN
    logic [31:0] r1_q;
    logic [7:0]  mask8;
    logic [3:0]  be1;
    logic        cross;
    logic [63:0] wd64;
    logic [31:0] wd1;

    assign mask8 = lane_mask(f3_q[1:0], addr_q[1:0]);
    assign be0   = mask8[3:0];
    assign be1   = mask8[7:4];
    assign cross = |be1;
    assign wd64  = {32'b0, wdata_q} << shamt;
    assign wd0   = wd64[31:0];
    assign wd1   = wd64[63:32];
    assign raw   = 32'({r1_q, r0_q} >> shamt);
`else
    assign be0   = 4'(lane_mask(f3_q[1:0], addr_q[1:0]));
    assign wd0   = wdata_q << shamt;
    assign raw   = r0_q >> shamt;
`endif

    // Load extension selected by the registered funct3.
    always_comb begin
        ext = raw;
        case (f3_q)
            3'b000:  ext = {{24{raw[7]}}, raw[7:0]};
            3'b001:  ext = {{16{raw[15]}}, raw[15:0]};
            3'b100:  ext = {24'b0, raw[7:0]};
            3'b101:  ext = {16'b0, raw[15:0]};
            default: ext = raw;
        endcase
    end

    // Next-state logic; beat states advance only on the ack cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = access_err(bus.i_addr, bus.i_we, bus.i_funct3)
                              ? RESP : BEAT0;
                end
            end
            BEAT0: begin
                if (bus.i_mem_ack) begin
`ifdef LSU_MISALIGN_EN
                    state_d = cross ? BEAT1 : RESP;
`else
                    state_d = RESP;
`endif
                end
            end
`ifdef LSU_MISALIGN_EN
            BEAT1: begin
                if (bus.i_mem_ack) state_d = RESP;
            end
`endif
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and request registers; request fields load only on accept.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            wdata_q <= 32'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q  <= bus.i_addr;
                we_q    <= bus.i_we;
                f3_q    <= bus.i_funct3;
                wdata_q <= bus.i_wdata;
                err_q   <= access_err(bus.i_addr, bus.i_we, bus.i_funct3);
            end
        end
    end

    // Load beat capture on each ack cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r0_q <= 32'b0;
`ifdef LSU_MISALIGN_EN
            r1_q <= 32'b0;
`endif
        end else begin
            if ((state_q == BEAT0) && bus.i_mem_ack && !we_q) r0_q <= bus.i_mem_rdata;
`ifdef LSU_MISALIGN_EN
            if ((state_q == BEAT1) && bus.i_mem_ack && !we_q) r1_q <= bus.i_mem_rdata;
`endif
        end
    end

    // Outputs decoded from state; everything idles at zero outside a beat or response.
    always_comb begin
        bus.o_req_ready = (state_q == IDLE);
        bus.o_rsp_valid = 1'b0;
        bus.o_err       = 1'b0;
        bus.o_rdata     = 32'b0;
        bus.o_mem_req   = 1'b0;
        bus.o_mem_we    = 1'b0;
        bus.o_mem_addr  = '0;
        bus.o_mem_be    = 4'b0;
        bus.o_mem_wdata = 32'b0;
        case (state_q)
            BEAT0: begin
                bus.o_mem_req   = 1'b1;
                bus.o_mem_we    = we_q;
                bus.o_mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
                bus.o_mem_be    = be0;
                bus.o_mem_wdata = wd0;
            end
`ifdef LSU_MISALIGN_EN
            BEAT1: begin
                bus.o_mem_req   = 1'b1;
                bus.o_mem_we    = we_q;
                bus.o_mem_addr  = {addr_q[ADDR_W-1:2] + 1'b1, 2'b00};
                bus.o_mem_be    = be1;
                bus.o_mem_wdata = wd1;
            end
`endif
            RESP: begin
                bus.o_rsp_valid = 1'b1;
                bus.o_err       = err_q;
                bus.o_rdata     = (err_q || we_q) ? 32'b0 : ext;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed bench for lsu_ctrl. Inputs change and outputs are
// sampled on the falling clock edge; the DUT acts on the rising edge.
module tb_lsu_ctrl;

  logic i_clk;
  logic i_rst_n;
  int   vec_cnt;
  int   miscompares;

  lsu_ctrl_if #(.ADDR_W(16)) bus ();

  lsu_ctrl #(.ADDR_W(16)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  // clock / reset block
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // driver: present a request on a falling edge, let it be accepted on the
  // next rising edge, then scramble the CPU inputs (they must be ignored)
  task automatic issue(input logic [15:0] a, input logic we, input logic [2:0] f3,
                       input logic [31:0] wd);
    bus.i_req_valid = 1'b1;
    bus.i_addr      = a;
    bus.i_we        = we;
    bus.i_funct3    = f3;
    bus.i_wdata     = wd;
    chk("req_ready_before_accept", 32'(bus.o_req_ready), 32'd1);
    @(negedge i_clk);
    bus.i_req_valid = 1'b0;
    bus.i_addr      = 16'h1000;
    bus.i_we        = ~we;
    bus.i_funct3    = 3'b111;
    bus.i_wdata     = 32'hFFFF_FFFF;
  endtask

  initial begin
    vec_cnt            = 0;
    miscompares        = 0;
    i_rst_n            = 1'b0;
    bus.i_req_valid    = 1'b0;
    bus.i_addr         = 16'h0;
    bus.i_we           = 1'b0;
    bus.i_funct3       = 3'b000;
    bus.i_wdata        = 32'h0;
    bus.i_mem_ack      = 1'b0;
    bus.i_mem_rdata    = 32'h0;

    // reset state
    @(negedge i_clk);
    chk("rst_ready",   32'(bus.o_req_ready), 32'd1);
    chk("rst_rsp",     32'(bus.o_rsp_valid), 32'd0);
    chk("rst_err",     32'(bus.o_err),       32'd0);
    chk("rst_rdata",   bus.o_rdata,          32'h0);
    chk("rst_mem_req", 32'(bus.o_mem_req),   32'd0);
    chk("rst_mem_we",  32'(bus.o_mem_we),    32'd0);
    chk("rst_mem_be",  32'(bus.o_mem_be),    32'd0);
    chk("rst_mem_addr",32'(bus.o_mem_addr),  32'd0);
    chk("rst_mem_wd",  bus.o_mem_wdata,      32'h0);

    // SW 0x2004, immediate ack, issued on the first edge after release
    i_rst_n       = 1'b1;
    bus.i_mem_ack = 1'b1;
    issue(16'h2004, 1'b1, 3'b010, 32'hDEAD_BEEF);
    chk("sw_mem_req",  32'(bus.o_mem_req),  32'd1);
    chk("sw_mem_we",   32'(bus.o_mem_we),   32'd1);
    chk("sw_mem_addr", 32'(bus.o_mem_addr), 32'h2004);
    chk("sw_mem_be",   32'(bus.o_mem_be),   32'hF);
    chk("sw_mem_wd",   bus.o_mem_wdata,     32'hDEAD_BEEF);
    chk("sw_rsp_early",32'(bus.o_rsp_valid),32'd0);
    @(negedge i_clk);
    chk("sw_rsp",      32'(bus.o_rsp_valid),32'd1);
    chk("sw_err",      32'(bus.o_err),      32'd0);
    chk("sw_rdata",    bus.o_rdata,         32'h0);
    chk("sw_resp_req", 32'(bus.o_mem_req),  32'd0);
    chk("sw_resp_be",  32'(bus.o_mem_be),   32'd0);
    chk("sw_resp_rdy", 32'(bus.o_req_ready),32'd0);
    @(negedge i_clk);
    chk("sw_idle_rsp", 32'(bus.o_rsp_valid),32'd0);

    // LB 0x2001, word 0x00008000
    bus.i_mem_rdata = 32'h0000_8000;
    issue(16'h2001, 1'b0, 3'b000, 32'h0);
    chk("lb_mem_be",   32'(bus.o_mem_be),   32'h2);
    chk("lb_mem_addr", 32'(bus.o_mem_addr), 32'h2000);
    chk("lb_mem_we",   32'(bus.o_mem_we),   32'd0);
    @(negedge i_clk);
    chk("lb_rsp",      32'(bus.o_rsp_valid),32'd1);
    chk("lb_rdata",    bus.o_rdata,         32'hFFFF_FF80);
    chk("lb_err",      32'(bus.o_err),      32'd0);
    @(negedge i_clk);

    // LBU 0x2001, same word
    issue(16'h2001, 1'b0, 3'b100, 32'h0);
    chk("lbu_mem_be",  32'(bus.o_mem_be),   32'h2);
    @(negedge i_clk);
    chk("lbu_rdata",   bus.o_rdata,         32'h0000_0080);
    @(negedge i_clk);

    // LH 0x2002, word 0x80010000 -> 0x8001 sign-extended
    bus.i_mem_rdata = 32'h8001_0000;
    issue(16'h2002, 1'b0, 3'b001, 32'h0);
    chk("lh_mem_be",   32'(bus.o_mem_be),   32'hC);
    @(negedge i_clk);
    chk("lh_rdata",    bus.o_rdata,         32'hFFFF_8001);
    @(negedge i_clk);

    // LHU 0x2002 -> zero-extended
    issue(16'h2002, 1'b0, 3'b101, 32'h0);
    @(negedge i_clk);
    chk("lhu_rdata",   bus.o_rdata,         32'h0000_8001);
    @(negedge i_clk);

    // SB 0x3003, data 0xAB -> lane 3
    issue(16'h3003, 1'b1, 3'b000, 32'h0000_00AB);
    chk("sb_mem_be",   32'(bus.o_mem_be),   32'h8);
    chk("sb_mem_addr", 32'(bus.o_mem_addr), 32'h3000);
    chk("sb_mem_wd",   bus.o_mem_wdata,     32'hAB00_0000);
    @(negedge i_clk);
    chk("sb_err",      32'(bus.o_err),      32'd0);
    chk("sb_rdata",    bus.o_rdata,         32'h0);
    @(negedge i_clk);

    // LW 0x2003: word-crossing
`ifdef LSU_MISALIGN_EN
    bus.i_mem_rdata = 32'h1122_3344;
    issue(16'h2003, 1'b0, 3'b010, 32'h0);
    chk("lwx_b0_be",   32'(bus.o_mem_be),   32'h8);
    chk("lwx_b0_addr", 32'(bus.o_mem_addr), 32'h2000);
    @(negedge i_clk);
    chk("lwx_b1_be",   32'(bus.o_mem_be),   32'h7);
    chk("lwx_b1_addr", 32'(bus.o_mem_addr), 32'h2004);
    chk("lwx_b1_rsp",  32'(bus.o_rsp_valid),32'd0);
    bus.i_mem_rdata = 32'h5566_7788;
    @(negedge i_clk);
    chk("lwx_rsp",     32'(bus.o_rsp_valid),32'd1);
    chk("lwx_rdata",   bus.o_rdata,         32'h6677_8811);
    chk("lwx_err",     32'(bus.o_err),      32'd0);
    @(negedge i_clk);
`else
    issue(16'h2003, 1'b0, 3'b010, 32'h0);
    chk("lwx_mem_req", 32'(bus.o_mem_req),  32'd0);
    chk("lwx_rsp",     32'(bus.o_rsp_valid),32'd1);
    chk("lwx_err",     32'(bus.o_err),      32'd1);
    chk("lwx_rdata",   bus.o_rdata,         32'h0);
    @(negedge i_clk);
`endif

    // SH 0x3FFF: touches 0x4000 -> error without any beat
    issue(16'h3FFF, 1'b1, 3'b001, 32'h0000_1234);
    chk("sh_mem_req",  32'(bus.o_mem_req),  32'd0);
    chk("sh_rsp",      32'(bus.o_rsp_valid),32'd1);
    chk("sh_err",      32'(bus.o_err),      32'd1);
    @(negedge i_clk);

    // LW 0x1000: outside region
    issue(16'h1000, 1'b0, 3'b010, 32'h0);
    chk("lwr_mem_req", 32'(bus.o_mem_req),  32'd0);
    chk("lwr_rsp",     32'(bus.o_rsp_valid),32'd1);
    chk("lwr_err",     32'(bus.o_err),      32'd1);
    chk("lwr_rdata",   bus.o_rdata,         32'h0);
    @(negedge i_clk);

    // funct3 011 load
    issue(16'h2000, 1'b0, 3'b011, 32'h0);
    chk("f3_011_err",  32'(bus.o_err),      32'd1);
    @(negedge i_clk);

    // store with funct3[2] = 1
    issue(16'h2000, 1'b1, 3'b100, 32'h0);
    chk("sbu_err",     32'(bus.o_err),      32'd1);
    chk("sbu_mem_req", 32'(bus.o_mem_req),  32'd0);
    @(negedge i_clk);

    // LW 0x2008 with ack held off for 5 cycles
    bus.i_mem_ack   = 1'b0;
    bus.i_mem_rdata = 32'hCAFE_F00D;
    issue(16'h2008, 1'b0, 3'b010, 32'h0);
    for (int i = 0; i < 5; i++) begin
      chk("stall_req",  32'(bus.o_mem_req),  32'd1);
      chk("stall_addr", 32'(bus.o_mem_addr), 32'h2008);
      chk("stall_be",   32'(bus.o_mem_be),   32'hF);
      chk("stall_we",   32'(bus.o_mem_we),   32'd0);
      chk("stall_rsp",  32'(bus.o_rsp_valid),32'd0);
      @(negedge i_clk);
    end
    bus.i_mem_ack = 1'b1;
    @(negedge i_clk);
    chk("stall_done_rsp",   32'(bus.o_rsp_valid), 32'd1);
    chk("stall_done_rdata", bus.o_rdata,          32'hCAFE_F00D);
    @(negedge i_clk);

    // reset on the third stalled cycle abandons the access
    bus.i_mem_ack = 1'b0;
    issue(16'h200C, 1'b0, 3'b010, 32'h0);
    chk("rb_c1_req", 32'(bus.o_mem_req), 32'd1);
    @(negedge i_clk);
    chk("rb_c2_req", 32'(bus.o_mem_req), 32'd1);
    @(negedge i_clk);
    i_rst_n = 1'b0;
    #1;
    chk("rb_req",   32'(bus.o_mem_req),   32'd0);
    chk("rb_ready", 32'(bus.o_req_ready), 32'd1);
    chk("rb_be",    32'(bus.o_mem_be),    32'd0);
    chk("rb_addr",  32'(bus.o_mem_addr),  32'd0);
    chk("rb_rsp",   32'(bus.o_rsp_valid), 32'd0);
    @(negedge i_clk);
    chk("rb_hold_rsp", 32'(bus.o_rsp_valid), 32'd0);

    // release and issue on the same edge
    i_rst_n         = 1'b1;
    bus.i_mem_ack   = 1'b1;
    bus.i_mem_rdata = 32'h0102_0304;
    issue(16'h2010, 1'b0, 3'b010, 32'h0);
    chk("post_rst_req",  32'(bus.o_mem_req),  32'd1);
    chk("post_rst_addr", 32'(bus.o_mem_addr), 32'h2010);
    chk("post_rst_rsp0", 32'(bus.o_rsp_valid),32'd0);
    @(negedge i_clk);
    chk("post_rst_rsp",  32'(bus.o_rsp_valid),32'd1);
    chk("post_rst_rdata",bus.o_rdata,         32'h0102_0304);
    @(negedge i_clk);
    chk("post_rst_idle", 32'(bus.o_rsp_valid),32'd0);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 16, the byte address width on both the CPU side and the memory side.
REQ-002 The block SHALL have the following ports, one per line:
- i_clk  in  1  the single clock.
- i_rst_n  in  1  asynchronous reset, active-low.
- i_req_valid  in  1  CPU load/store request.
- o_req_ready  out  1  block can accept a request.
- i_addr  in  ADDR_W  byte address.
- i_we  in  1  1 = store, 0 = load.
- i_funct3  in  3  000 = B, 001 = H, 010 = W, 100 = BU, 101 = HU.
- i_wdata  in  32  store data, right-aligned.
- o_rsp_valid  out  1  one-cycle completion pulse.
- o_rdata  out  32  extended load data.
- o_err  out  1  error flag, qualified by o_rsp_valid.
- o_mem_req  out  1  memory beat request.
- o_mem_we  out  1  beat is a write.
- o_mem_addr  out  ADDR_W  word-aligned address, [1:0] = 0.
- i_mem_ack  in  1  beat accepted; i_mem_rdata is valid in the same cycle.
- i_mem_rdata  in  32  memory read word.
- o_mem_be  out  4  byte-lane enables.
- o_mem_wdata  out  32  lane-positioned store data.

Function
REQ-003 The FSM SHALL have exactly the states IDLE, BEAT0, BEAT1 and RESP.
REQ-004 o_req_ready SHALL be 1 only in IDLE; a request SHALL be accepted on a cycle where i_req_valid and o_req_ready are both 1.
REQ-005 On accept, the block SHALL register addr, we, funct3 and wdata, and the CPU-side inputs SHALL then be ignored until the block returns to IDLE.
REQ-006 The access SHALL be flagged as an error in any of these cases:
- funct3 is 011, 110 or 111.
- A store has funct3[2] = 1.
- Any byte touched has addr[15:12] outside {2, 3}.
REQ-007 An error access SHALL go IDLE -> RESP with no memory beat, and RESP SHALL then drive o_err = 1 and o_rdata = 0.
REQ-008 Let off = addr[1:0] and size = 1, 2 or 4; an access SHALL be "crossing" when off + size > 4.
REQ-009 A non-crossing access SHALL go IDLE -> BEAT0 -> RESP and SHALL issue one beat with:
- o_mem_addr = {addr[ADDR_W-1:2], 2'b00}.
- o_mem_be = the size-wide mask shifted left by off.
- o_mem_wdata = wdata << (8*off).
REQ-010 A crossing access SHALL go IDLE -> BEAT0 -> BEAT1 -> RESP.
- BEAT0: word address W, lanes off..3, wdata << (8*off).
- BEAT1: word address W + 4, lanes 0..(off+size-5), wdata >> (8*(4-off)).
REQ-011 In BEAT0 and BEAT1, o_mem_req SHALL stay 1 with address, be, we and wdata held stable until i_mem_ack, and the state SHALL advance on the ack cycle.
REQ-012 On each load beat's ack cycle, i_mem_rdata SHALL be captured into beat registers r0 and r1.
REQ-013 In RESP, the raw load value SHALL be ({r1, r0} >> (8*off))[31:0], extended as follows:
- B: sign-extend bit 7.
- H: sign-extend bit 15.
- W: unchanged.
- BU/HU: zero-extend.
REQ-014 For a store, o_rdata SHALL be 0 in RESP.
REQ-015 RESP SHALL last exactly one cycle with o_rsp_valid = 1 and SHALL return to IDLE.
REQ-016 A new request SHALL be acceptable on the cycle after RESP, giving minimum latency accept -> o_rsp_valid of 2 cycles for one beat and 3 cycles for two beats, each plus ack wait.
REQ-017 o_mem_req SHALL be 0 in IDLE and RESP, and o_mem_be SHALL be 0 whenever o_mem_req = 0.
REQ-018 An i_mem_ack while o_mem_req = 0 SHALL be ignored.

Reset
REQ-019 Asserting i_rst_n = 0 SHALL asynchronously force state IDLE and force the following outputs:
- 0: o_rsp_valid, o_err, o_rdata, o_mem_req, o_mem_we, o_mem_be, o_mem_addr, o_mem_wdata.
- 1 (IDLE): o_req_ready.
REQ-020 Reset mid-beat SHALL abandon the access with no response and no further memory beat, and any beat already acked SHALL NOT be rolled back.
REQ-021 On release of reset, the first request SHALL be acceptable on the first clock edge.

Configuration
REQ-022 The block SHALL use macro LSU_MISALIGN_EN to control crossing accesses.
- Defined: crossing accesses SHALL split per REQ-010.
- Undefined: any crossing access SHALL be an error per REQ-007, the BEAT1 state and r1 SHALL be absent, and non-crossing unaligned accesses SHALL still be a single beat.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- SW addr 0x2004, data 0xDEADBEEF, ack immediate -> one beat, addr 0x2004, be 1111, wdata 0xDEADBEEF; o_rsp_valid 2 cycles after accept, o_err 0.
- LB addr 0x2001, memory word 0x0000_8000 -> be 0010, o_rdata 0xFFFF_FF80; LBU at the same address -> 0x0000_0080.
- With LSU_MISALIGN_EN: LW addr 0x2003, word 0x2000 = 0x11223344, word 0x2004 = 0x55667788 -> beats be 1000 then 0111, o_rdata 0x66778811.
- Without LSU_MISALIGN_EN: SH addr 0x3FFF -> no o_mem_req, o_rsp_valid with o_err 1.
- LW addr 0x1000 -> o_err 1, o_rdata 0, no beat; funct3 = 011 -> o_err 1.
- i_mem_ack held 0 for 5 cycles in BEAT0 -> outputs stable throughout; reset asserted on cycle 3 -> IDLE, o_mem_req 0, no o_rsp_valid.
